// File: rtl/tx_piso_serializer.sv
// ---------------------------------------------------------------------------
// tx_piso_serializer
//
// Transmit-side 10-bit parallel-in / serial-out serializer. Sits between the
// 8b/10b encoder and the line driver. Code groups arrive on a valid/ready
// handshake into a one-word holding buffer. They are shifted out LSB first,
// one bit per BitCLK. When no data is waiting at a word boundary, a K28.5
// comma idle is inserted. Idles alternate between RD- and RD+ so the receiver
// keeps word alignment.
//
// Ports
//   BitCLK         in   bit-rate clock, all state on its rising edge
//   Reset          in   synchronous active-high reset
//   TxParallel_10  in   [9:0] code group, bit 0 goes on the wire first
//   TxValid        in   TxParallel_10 is valid
//   TxReady        out  combinational, high when the holding buffer is free
//   Serial         out  registered serial line bit
//   WordStart      out  registered, high while Serial carries bit 0 of a group
//   TxIdle         out  registered, high for every bit of an inserted idle
// ---------------------------------------------------------------------------
module tx_piso_serializer (
  input  logic       BitCLK,
  input  logic       Reset,
  input  logic [9:0] TxParallel_10,
  input  logic       TxValid,
  output logic       TxReady,
  output logic       Serial,
  output logic       WordStart,
  output logic       TxIdle
);

  // K28.5 comma code groups, bit 0 ('a') is transmitted first.
  localparam logic [9:0] IDLE_NEG = 10'b0101111100;
  localparam logic [9:0] IDLE_POS = 10'b1010000011;

  // Last bit index of a code group; reaching it means the next edge reloads.
  localparam logic [3:0] LAST_BIT = 4'd9;

  // Shift word and bit pointer.
  logic [9:0] word_q, word_d;
  logic [3:0] bitcnt_q, bitcnt_d;

  // One-entry holding buffer between the handshake and the shifter.
  logic [9:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;

  // Idle disparity selector and the "active word is an idle" marker.
  logic       idle_sel_q, idle_sel_d;
  logic       word_is_idle_q, word_is_idle_d;

  // Registered line outputs.
  logic       serial_q, serial_d;
  logic       word_start_q, word_start_d;
  logic       tx_idle_q, tx_idle_d;

  // Decoded control.
  logic       accept;
  logic       boundary;
  logic       cur_bit;
  logic [9:0] idle_word;

  // TxReady is forced high during reset so upstream sees a free buffer.
  // Accepts are still blocked because accept also qualifies on ~Reset.
  assign TxReady = ~hold_full_q | Reset;

  assign accept  = TxValid & TxReady & ~Reset;

  // Counter values 10..15 cannot occur in normal operation. They are
  // treated as a boundary so a corrupted counter recovers within one edge.
  assign boundary = (bitcnt_q >= LAST_BIT);

  // An out-of-range counter would index past the word, so drive 0 instead.
  assign cur_bit = (bitcnt_q <= LAST_BIT) ? word_q[bitcnt_q] : 1'b0;

  assign idle_word = idle_sel_q ? IDLE_POS : IDLE_NEG;

  // Next-state logic. Each edge emits the current bit and updates the
  // pointer. At a word boundary the shift word is reloaded with this
  // priority:
  //   1. a buffered word from the holding register,
  //   2. a word handed over on this very edge (bypasses the buffer),
  //   3. a comma idle, which also flips the idle disparity.
  // On other edges an accepted word is parked in the holding register.
  always_comb begin
    word_d         = word_q;
    bitcnt_d       = bitcnt_q;
    hold_d         = hold_q;
    hold_full_d    = hold_full_q;
    idle_sel_d     = idle_sel_q;
    word_is_idle_d = word_is_idle_q;

    serial_d       = cur_bit;
    word_start_d   = (bitcnt_q == 4'd0);
    tx_idle_d      = word_is_idle_q;

    if (boundary) begin
      bitcnt_d = 4'd0;
      if (hold_full_q) begin
        word_d         = hold_q;
        hold_full_d    = 1'b0;
        word_is_idle_d = 1'b0;
      end else if (accept) begin
        word_d         = TxParallel_10;
        word_is_idle_d = 1'b0;
      end else begin
        word_d         = idle_word;
        word_is_idle_d = 1'b1;
        idle_sel_d     = ~idle_sel_q;
      end
    end else begin
      bitcnt_d = bitcnt_q + 4'd1;
      if (accept) begin
        hold_d      = TxParallel_10;
        hold_full_d = 1'b1;
      end
    end
  end

  // State registers. Reset parks the pointer on the last bit, so the first
  // edge after release is a boundary that loads either data or IDLE_NEG.
  // Any partly sent word and any buffered word are dropped.
  always_ff @(posedge BitCLK) begin
    if (Reset) begin
      word_q         <= 10'd0;
      bitcnt_q       <= LAST_BIT;
      hold_q         <= 10'd0;
      hold_full_q    <= 1'b0;
      idle_sel_q     <= 1'b0;
      word_is_idle_q <= 1'b0;
      serial_q       <= 1'b0;
      word_start_q   <= 1'b0;
      tx_idle_q      <= 1'b0;
    end else begin
      word_q         <= word_d;
      bitcnt_q       <= bitcnt_d;
      hold_q         <= hold_d;
      hold_full_q    <= hold_full_d;
      idle_sel_q     <= idle_sel_d;
      word_is_idle_q <= word_is_idle_d;
      serial_q       <= serial_d;
      word_start_q   <= word_start_d;
      tx_idle_q      <= tx_idle_d;
    end
  end

  assign Serial    = serial_q;
  assign WordStart = word_start_q;
  assign TxIdle    = tx_idle_q;

endmodule

// File: tb/tb_tx_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_tx_piso_serializer
//
// Directed bench for tx_piso_serializer. Each step queues the line bits it
// expects (serial bit, word-start flag, idle flag) and then clocks the design.
// One entry is popped and compared after every edge.
// ---------------------------------------------------------------------------
module tb_tx_piso_serializer;

  localparam logic [9:0] IDLE_NEG = 10'b0101111100;
  localparam logic [9:0] IDLE_POS = 10'b1010000011;

  logic       BitCLK;
  logic       Reset;
  logic [9:0] TxParallel_10;
  logic       TxValid;
  logic       TxReady;
  logic       Serial;
  logic       WordStart;
  logic       TxIdle;

  typedef struct {
    logic ser;
    logic ws;
    logic idl;
  } exp_t;

  exp_t expQ[$];
  int   assertCount;
  int   failCount;

  tx_piso_serializer dut (
    .BitCLK        (BitCLK),
    .Reset         (Reset),
    .TxParallel_10 (TxParallel_10),
    .TxValid       (TxValid),
    .TxReady       (TxReady),
    .Serial        (Serial),
    .WordStart     (WordStart),
    .TxIdle        (TxIdle)
  );

  // Free-running bit clock, period 10.
  initial begin
    BitCLK = 1'b0;
    forever #5 BitCLK = ~BitCLK;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive the handshake inputs.
  task automatic applyStimulus(input logic valid, input logic [9:0] data);
    TxValid       = valid;
    TxParallel_10 = data;
  endtask

  // Single-bit comparison with accounting.
  task automatic checkBit(input string tag, input logic obs, input logic exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Queue the ten bits of one code group, LSB first.
  task automatic pushGroup(input logic [9:0] g, input logic idl);
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      e.ser = g[i];
      e.ws  = (i == 0);
      e.idl = idl;
      expQ.push_back(e);
    end
  endtask

  // The first edge after reset shifts out word[9] of the cleared word.
  task automatic pushResetBit();
    exp_t e;
    e.ser = 1'b0;
    e.ws  = 1'b0;
    e.idl = 1'b0;
    expQ.push_back(e);
  endtask

  // Pop the next expected line state and compare against the outputs.
  task automatic checkOutput(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      assertCount++;
      failCount++;
      $error("[TB] FAIL %s_queue: observed output expected no more edges", tag);
    end else begin
      e = expQ.pop_front();
      checkBit({tag, "_serial"}, Serial, e.ser);
      checkBit({tag, "_wordstart"}, WordStart, e.ws);
      checkBit({tag, "_txidle"}, TxIdle, e.idl);
    end
  endtask

  // Advance one edge and sample one time unit later.
  task automatic tick();
    @(posedge BitCLK);
    #1;
  endtask

  // Hold reset for a number of edges, check the cleared outputs, then release.
  task automatic doReset(input int cycles, input string tag);
    applyStimulus(1'b0, 10'd0);
    Reset = 1'b1;
    repeat (cycles) begin
      tick();
      checkBit({tag, "_rst_serial"}, Serial, 1'b0);
      checkBit({tag, "_rst_wordstart"}, WordStart, 1'b0);
      checkBit({tag, "_rst_txidle"}, TxIdle, 1'b0);
      checkBit({tag, "_rst_ready"}, TxReady, 1'b1);
    end
    Reset = 1'b0;
    expQ.delete();
    pushResetBit();
  endtask

  initial begin
    logic expReady;
    assertCount = 0;
    failCount   = 0;
    Reset       = 1'b1;
    applyStimulus(1'b0, 10'd0);

    // Idle only: alternating commas, starting with RD-.
    $display("[TB] idle only");
    doReset(3, "idle");
    pushGroup(IDLE_NEG, 1'b1);
    pushGroup(IDLE_POS, 1'b1);
    pushGroup(IDLE_NEG, 1'b1);
    pushGroup(IDLE_POS, 1'b1);
    for (int n = 1; n <= 41; n++) begin
      tick();
      checkOutput("idle");
      checkBit("idle_ready", TxReady, 1'b1);
    end
    checkInt("idle_drained", expQ.size(), 0);

    // Bypass: word handed over at the first boundary edge.
    $display("[TB] bypass");
    doReset(2, "byp");
    applyStimulus(1'b1, 10'h2A5);
    checkBit("byp_ready_pre", TxReady, 1'b1);
    pushGroup(10'h2A5, 1'b0);
    pushGroup(IDLE_NEG, 1'b1);
    for (int n = 1; n <= 21; n++) begin
      tick();
      checkOutput("byp");
      if (n == 1) applyStimulus(1'b0, 10'd0);
    end
    checkInt("byp_drained", expQ.size(), 0);

    // Back-to-back: three contiguous groups, buffer blocks until boundary.
    $display("[TB] back-to-back");
    doReset(2, "b2b");
    applyStimulus(1'b1, 10'h155);
    pushGroup(10'h155, 1'b0);
    pushGroup(10'h0AA, 1'b0);
    pushGroup(10'h3FF, 1'b0);
    pushGroup(IDLE_NEG, 1'b1);
    for (int n = 1; n <= 41; n++) begin
      tick();
      checkOutput("b2b");
      if (n == 1)       applyStimulus(1'b1, 10'h0AA);
      else if (n == 2)  applyStimulus(1'b1, 10'h3FF);
      else if (n == 12) applyStimulus(1'b0, 10'd0);
      expReady = !((n >= 2 && n <= 10) || (n >= 12 && n <= 20));
      checkBit("b2b_ready", TxReady, expReady);
    end
    checkInt("b2b_drained", expQ.size(), 0);

    // Gap: one RD- idle between words, the following idle is RD+.
    $display("[TB] gap");
    doReset(2, "gap");
    applyStimulus(1'b1, 10'h17C);
    pushGroup(10'h17C, 1'b0);
    pushGroup(IDLE_NEG, 1'b1);
    pushGroup(10'h283, 1'b0);
    pushGroup(IDLE_POS, 1'b1);
    for (int n = 1; n <= 41; n++) begin
      tick();
      checkOutput("gap");
      if (n == 1)       applyStimulus(1'b0, 10'd0);
      else if (n == 13) applyStimulus(1'b1, 10'h283);
      else if (n == 14) applyStimulus(1'b0, 10'd0);
      expReady = !(n >= 14 && n <= 20);
      checkBit("gap_ready", TxReady, expReady);
    end
    checkInt("gap_drained", expQ.size(), 0);

    // Late accept: word offered mid-idle at bitcnt 3, sent after the idle.
    $display("[TB] late accept");
    doReset(2, "late");
    pushGroup(IDLE_NEG, 1'b1);
    pushGroup(10'h0F0, 1'b0);
    pushGroup(IDLE_POS, 1'b1);
    for (int n = 1; n <= 31; n++) begin
      tick();
      checkOutput("late");
      if (n == 4)      applyStimulus(1'b1, 10'h0F0);
      else if (n == 5) applyStimulus(1'b0, 10'd0);
      expReady = !(n >= 5 && n <= 10);
      checkBit("late_ready", TxReady, expReady);
    end
    checkInt("late_drained", expQ.size(), 0);

    // Reset mid-operation with a full holding buffer.
    $display("[TB] reset mid-word");
    doReset(2, "mid");
    applyStimulus(1'b1, 10'h155);
    pushGroup(10'h155, 1'b0);
    for (int n = 1; n <= 6; n++) begin
      tick();
      checkOutput("mid");
      if (n == 1)      applyStimulus(1'b1, 10'h0AA);
      else if (n == 2) applyStimulus(1'b0, 10'd0);
      if (n >= 2) checkBit("mid_ready_full", TxReady, 1'b0);
    end
    Reset = 1'b1;
    #1;
    checkBit("mid_ready_in_reset", TxReady, 1'b1);
    tick();
    checkBit("mid_rst_serial", Serial, 1'b0);
    checkBit("mid_rst_wordstart", WordStart, 1'b0);
    checkBit("mid_rst_txidle", TxIdle, 1'b0);
    Reset = 1'b0;
    #1;
    checkBit("mid_ready_after", TxReady, 1'b1);
    expQ.delete();
    pushResetBit();
    pushGroup(IDLE_NEG, 1'b1);
    pushGroup(IDLE_POS, 1'b1);
    pushGroup(IDLE_NEG, 1'b1);
    for (int n = 1; n <= 31; n++) begin
      tick();
      checkOutput("restart");
      checkBit("restart_ready", TxReady, 1'b1);
    end
    checkInt("restart_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
